// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and write-port bundle for the 2W2R register file.
package regfile_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_NREGS = 4;
  localparam int unsigned DEF_CNT_W = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r = r + 1;
    return r;
  endfunction

  localparam int unsigned DEF_AW = clog2(DEF_NREGS);

  typedef struct packed {
    logic                en;
    logic [DEF_AW-1:0]   addr;
    logic [DEF_WIDTH-1:0] data;
  } wr_port_t;

endpackage

// File: rtl/regfile_write_arb.sv
// Combinational write arbiter: per-register write enables, port-D data select and the
// raw same-address collision term. Out-of-range addresses decode to no register.
module regfile_write_arb
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = clog2(NREGS)
) (
  input  logic             wr_en_d_i,
  input  logic [AW-1:0]    wr_addr_d_i,
  input  logic             wr_en_s_i,
  input  logic [AW-1:0]    wr_addr_s_i,
  output logic [NREGS-1:0] we_o,
  output logic [NREGS-1:0] sel_d_o,
  output logic             coll_o
);

  logic [NREGS-1:0] hit_d, hit_s;

  always_comb begin
    hit_d = '0;
    hit_s = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      hit_d[i] = wr_en_d_i && (wr_addr_d_i == AW'(i));
      hit_s[i] = wr_en_s_i && (wr_addr_s_i == AW'(i));
    end
  end

  // Collision only counts when both ports hit the same in-range register.
  assign coll_o  = |(hit_d & hit_s);
  assign we_o    = hit_d | hit_s;
  assign sel_d_o = hit_d;

endmodule

// File: rtl/regfile_2w2r.sv
// NREGS x WIDTH register file, two write ports (D has priority), two combinational reads,
// collision pulse and saturating collision counter. Define REGFILE_BYPASS_EN for write-to-read bypass.
module regfile_2w2r
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned AW    = clog2(NREGS),
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_d,
  input  logic [AW-1:0]    wr_addr_d,
  input  logic [WIDTH-1:0] wr_data_d,
  input  logic             wr_en_s,
  input  logic [AW-1:0]    wr_addr_s,
  input  logic [WIDTH-1:0] wr_data_s,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             collision,
  output logic [CNT_W-1:0] coll_cnt
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] rd_src [NREGS];
  logic [NREGS-1:0] we, sel_d;
  logic             coll_raw;
  logic             coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  regfile_write_arb #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_arb (
    .wr_en_d_i   (wr_en_d),
    .wr_addr_d_i (wr_addr_d),
    .wr_en_s_i   (wr_en_s),
    .wr_addr_s_i (wr_addr_s),
    .we_o        (we),
    .sel_d_o     (sel_d),
    .coll_o      (coll_raw)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we[i]) regs_d[i] = sel_d[i] ? wr_data_d : wr_data_s;
    end
  end

  assign coll_d = coll_raw;
  assign cnt_d  = (coll_raw && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  // Bypass reads the next-state array, which already holds this cycle's winning write.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
`ifdef REGFILE_BYPASS_EN
      rd_src[i] = regs_d[i];
`else
      rd_src[i] = regs_q[i];
`endif
    end
  end

  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (rd_addr_a == AW'(i)) rd_data_a = rd_src[i];
      if (rd_addr_b == AW'(i)) rd_data_b = rd_src[i];
    end
  end

  assign collision = coll_q;
  assign coll_cnt  = cnt_q;

endmodule

// File: tb/tb_regfile_2w2r.sv
// Self-checking bench for regfile_2w2r: directed table, corner sequences, random vs. array model.
module tb_regfile_2w2r;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en_d, wr_en_s, collision;
  logic [1:0]  wr_addr_d, wr_addr_s, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data_d, wr_data_s, rd_data_a, rd_data_b;
  logic [7:0]  coll_cnt;

  logic        e5_en_d, e5_en_s, e5_coll;
  logic [2:0]  e5_ad, e5_as, e5_ra, e5_rb;
  logic [15:0] e5_dd, e5_ds, e5_rda, e5_rdb;
  logic [7:0]  e5_cnt;

  regfile_2w2r #(.WIDTH(16), .NREGS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .wr_en_d(wr_en_d), .wr_addr_d(wr_addr_d), .wr_data_d(wr_data_d),
    .wr_en_s(wr_en_s), .wr_addr_s(wr_addr_s), .wr_data_s(wr_data_s),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .collision(collision), .coll_cnt(coll_cnt)
  );

  regfile_2w2r #(.WIDTH(16), .NREGS(5), .CNT_W(8)) dut5 (
    .clk(clk), .rst(rst),
    .wr_en_d(e5_en_d), .wr_addr_d(e5_ad), .wr_data_d(e5_dd),
    .wr_en_s(e5_en_s), .wr_addr_s(e5_as), .wr_data_s(e5_ds),
    .rd_addr_a(e5_ra), .rd_data_a(e5_rda),
    .rd_addr_b(e5_rb), .rd_data_b(e5_rdb),
    .collision(e5_coll), .coll_cnt(e5_cnt)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [15:0] mem [4];
  int unsigned exp_cnt;
  logic        exp_coll;

  typedef struct {
    wr_port_t    d, s;
    logic [1:0]  ra, rb;
    logic [15:0] exp_a, exp_b;
    logic        exp_coll;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ed, input logic [1:0] ad, input logic [15:0] dd,
                              input logic es, input logic [1:0] as, input logic [15:0] ds,
                              input logic [1:0] ra, input logic [1:0] rb,
                              input logic [15:0] ea, input logic [15:0] eb,
                              input logic ec, input logic [7:0] ecnt);
    vec_t v;
    v.d.en = ed; v.d.addr = ad; v.d.data = dd;
    v.s.en = es; v.s.addr = as; v.s.data = ds;
    v.ra = ra; v.rb = rb; v.exp_a = ea; v.exp_b = eb; v.exp_coll = ec; v.exp_cnt = ecnt;
    return v;
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] a);
    logic [15:0] v;
    v = mem[a];
`ifdef REGFILE_BYPASS_EN
    if (wr_en_d && wr_addr_d == a) v = wr_data_d;
    else if (wr_en_s && wr_addr_s == a) v = wr_data_s;
`endif
    return v;
  endfunction

  task automatic drive(input wr_port_t d, input wr_port_t s, input logic [1:0] ra, input logic [1:0] rb);
    wr_en_d = d.en; wr_addr_d = d.addr; wr_data_d = d.data;
    wr_en_s = s.en; wr_addr_s = s.addr; wr_data_s = s.data;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic idle();
    wr_en_d = 1'b0; wr_en_s = 1'b0;
    e5_en_d = 1'b0; e5_en_s = 1'b0;
  endtask

  task automatic tick();
    logic c;
    c = wr_en_d && wr_en_s && (wr_addr_d == wr_addr_s);
    @(posedge clk);
    if (wr_en_s) mem[wr_addr_s] = wr_data_s;
    if (wr_en_d) mem[wr_addr_d] = wr_data_d;
    exp_coll = c;
    if (c && exp_cnt < 255) exp_cnt++;
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mem[i] = '0;
    exp_cnt = 0;
    exp_coll = 1'b0;
  endtask

  initial begin
    wr_port_t pd, ps;
    logic [15:0] exp5 [5];

    rst = 1'b1;
    idle();
    wr_addr_d = '0; wr_addr_s = '0; wr_data_d = '0; wr_data_s = '0;
    rd_addr_a = 2'd0; rd_addr_b = 2'd3;
    e5_ad = '0; e5_as = '0; e5_dd = '0; e5_ds = '0; e5_ra = '0; e5_rb = '0;
    model_reset();

    #12;
    check("reset_rd_a", 32'(rd_data_a), 32'h0);
    check("reset_rd_b", 32'(rd_data_b), 32'h0);
    check("reset_coll", 32'(collision), 32'h0);
    check("reset_cnt", 32'(coll_cnt), 32'h0);
    rst = 1'b0;

    tbl[0] = mk(1, 2'd1, 16'hAAAA, 1, 2'd2, 16'h5555, 2'd1, 2'd2, 16'hAAAA, 16'h5555, 0, 8'd0);
    tbl[1] = mk(1, 2'd3, 16'h1234, 1, 2'd3, 16'hFFFF, 2'd3, 2'd2, 16'h1234, 16'h5555, 1, 8'd1);
    tbl[2] = mk(0, 2'd3, 16'h0000, 0, 2'd3, 16'h0000, 2'd3, 2'd3, 16'h1234, 16'h1234, 0, 8'd1);
    tbl[3] = mk(0, 2'd0, 16'h9999, 1, 2'd0, 16'h00FF, 2'd0, 2'd1, 16'h00FF, 16'hAAAA, 0, 8'd1);
    tbl[4] = mk(1, 2'd0, 16'hC0DE, 0, 2'd0, 16'h7777, 2'd0, 2'd0, 16'hC0DE, 16'hC0DE, 0, 8'd1);

    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].d, tbl[i].s, tbl[i].ra, tbl[i].rb);
      tick();
      idle();
      #1;
      check($sformatf("tbl%0d_rd_a", i), 32'(rd_data_a), 32'(tbl[i].exp_a));
      check($sformatf("tbl%0d_rd_b", i), 32'(rd_data_b), 32'(tbl[i].exp_b));
      check($sformatf("tbl%0d_coll", i), 32'(collision), 32'(tbl[i].exp_coll));
      check($sformatf("tbl%0d_cnt", i), 32'(coll_cnt), 32'(tbl[i].exp_cnt));
    end

    // Same-cycle read of a register being written.
    pd.en = 1'b1; pd.addr = 2'd0; pd.data = 16'hBEEF;
    ps.en = 1'b0; ps.addr = 2'd1; ps.data = 16'h0;
    drive(pd, ps, 2'd0, 2'd1);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("raw_same_cycle", 32'(rd_data_a), 32'hBEEF);
`else
    check("raw_same_cycle", 32'(rd_data_a), 32'hC0DE);
`endif
    check("raw_other_port", 32'(rd_data_b), 32'hAAAA);
    tick();
    idle();
    #1;
    check("raw_next_cycle", 32'(rd_data_a), 32'hBEEF);

    // Long collision run: counter saturates, pulse stays high.
    for (int i = 0; i < 300; i++) begin
      pd.en = 1'b1; pd.addr = 2'd1; pd.data = 16'(i);
      ps.en = 1'b1; ps.addr = 2'd1; ps.data = ~16'(i);
      drive(pd, ps, 2'd1, 2'd2);
      tick();
      check("sat_coll_hold", 32'(collision), 32'h1);
      check("sat_cnt", 32'(coll_cnt), 32'(exp_cnt));
    end
    check("sat_cnt_255", 32'(coll_cnt), 32'd255);
    idle();
    tick();
    check("sat_coll_drop", 32'(collision), 32'h0);
    check("sat_cnt_hold", 32'(coll_cnt), 32'd255);
    check("sat_reg1_d_wins", 32'(rd_data_a), 32'd299);

    // Randomised traffic against the array model.
    for (int i = 0; i < 200; i++) begin
      pd.en = 1'($urandom_range(1)); pd.addr = 2'($urandom_range(3)); pd.data = 16'($urandom);
      ps.en = 1'($urandom_range(1)); ps.addr = 2'($urandom_range(3)); ps.data = 16'($urandom);
      if ($urandom_range(3) == 0) ps.addr = pd.addr;
      drive(pd, ps, 2'($urandom_range(3)), 2'($urandom_range(3)));
      #1;
      check("rnd_rd_a", 32'(rd_data_a), 32'(model_read(rd_addr_a)));
      check("rnd_rd_b", 32'(rd_data_b), 32'(model_read(rd_addr_b)));
      tick();
      check("rnd_coll", 32'(collision), 32'(exp_coll));
      check("rnd_cnt", 32'(coll_cnt), 32'(exp_cnt));
    end

    // Asynchronous reset mid-cycle with nonzero contents.
    idle();
    mem[1] = mem[1];
    @(posedge clk);
    #3;
    rd_addr_a = 2'd1; rd_addr_b = 2'd3;
    rst = 1'b1;
    #1;
    check("async_rd_a", 32'(rd_data_a), 32'h0);
    check("async_rd_b", 32'(rd_data_b), 32'h0);
    check("async_cnt", 32'(coll_cnt), 32'h0);
    check("async_coll", 32'(collision), 32'h0);
    model_reset();

    // Write pending while reset is released: first clean edge performs it.
    pd.en = 1'b1; pd.addr = 2'd2; pd.data = 16'h7777;
    ps.en = 1'b1; ps.addr = 2'd3; ps.data = 16'h3333;
    drive(pd, ps, 2'd2, 2'd3);
    #2;
    rst = 1'b0;
    tick();
    idle();
    #1;
    check("rst_rel_rd_a", 32'(rd_data_a), 32'h7777);
    check("rst_rel_rd_b", 32'(rd_data_b), 32'h3333);

    // NREGS = 5: out-of-range writes ignored, reads return 0, no collision counted.
    e5_en_d = 1'b1; e5_ad = 3'd4; e5_dd = 16'h4444;
    tick();
    idle();
    e5_ra = 3'd4;
    #1;
    check("n5_reg4", 32'(e5_rda), 32'h4444);
    e5_en_d = 1'b1; e5_ad = 3'd7; e5_dd = 16'h0F0F;
    e5_en_s = 1'b1; e5_as = 3'd7; e5_ds = 16'h1111;
    e5_rb = 3'd7;
    #1;
    check("n5_oob_same_cycle", 32'(e5_rdb), 32'h0);
    tick();
    idle();
    #1;
    check("n5_oob_coll", 32'(e5_coll), 32'h0);
    check("n5_oob_cnt", 32'(e5_cnt), 32'h0);
    check("n5_oob_rd", 32'(e5_rdb), 32'h0);
    exp5[0] = 16'h0; exp5[1] = 16'h0; exp5[2] = 16'h0; exp5[3] = 16'h0; exp5[4] = 16'h4444;
    for (int i = 0; i < 5; i++) begin
      e5_ra = 3'(i);
      #1;
      check($sformatf("n5_reg%0d_unchanged", i), 32'(e5_rda), 32'(exp5[i]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
